// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Multiplexed N-digit seven-segment driver with tear-free updates,
//            leading-zero blanking, per-digit blink and anti-ghosting guard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int GUARD          = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    input  logic [NUM_DIGITS-1:0]     blink_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      update_pending,
    output logic                      frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
    localparam logic             SEG_INV   = (SEG_ACTIVE_LOW != 0);
    localparam logic             AN_INV    = (AN_ACTIVE_LOW != 0);

    // Scan position
    logic [DIV_W-1:0]          div_q, div_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    // Shadow / display registers
    logic [4*NUM_DIGITS-1:0]   shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
    logic [4*NUM_DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic                      pending_q, pending_d;
    // Blink timing
    logic [BLK_W-1:0]          blk_cnt_q, blk_cnt_d;
    logic                      blink_phase_q, blink_phase_d;
    // Registered pin drivers
    logic                      frame_tick_q, frame_tick_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    logic                      at_div_last;
    logic                      boundary;
    logic [NUM_DIGITS-1:0]     lz_blank;
    logic                      upper_zero;
    logic [3:0]                nibble;
    logic                      dark;
    logic                      digit_off;
    logic [6:0]                seg_act;
    logic                      dp_act;
    logic [NUM_DIGITS-1:0]     an_act;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        at_div_last = (div_q == DIV_LAST);
        boundary    = at_div_last && (idx_q == IDX_LAST);
        div_d       = at_div_last ? '0 : div_q + DIV_W'(1);
        idx_d       = idx_q;
        if (at_div_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load in the boundary cycle still lands in the shadow; the copy uses
    // the shadow contents from before that load.
    always_comb begin
        shadow_val_d = load ? value_in : shadow_val_q;
        shadow_dp_d  = load ? dp_in    : shadow_dp_q;
        pending_d    = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (boundary && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
        end
    end

    always_comb begin
        blk_cnt_d     = blk_cnt_q;
        blink_phase_d = blink_phase_q;
        if (boundary) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d     = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
        frame_tick_d = boundary;
    end

    // Scanning from the top digit down, a digit is blanked while everything
    // above and including it is zero; digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_val_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_blank[k] = blank_lz && upper_zero;
            end
        end
    end

    // A leading-zero blanked digit is also left deselected; it is dark either way.
    always_comb begin
        nibble    = disp_val_q[4*int'(idx_q) +: 4];
        dark      = blink_phase_q && blink_en[idx_q];
        digit_off = dark || lz_blank[idx_q];
        seg_act   = digit_off ? 7'h00 : seg_decode(nibble);
        dp_act    = disp_dp_q[idx_q] && !dark;
        an_act    = '0;
        if ((div_q >= DIV_GUARD) && !digit_off) begin
            an_act[idx_q] = 1'b1;
        end
        seg_d = seg_act ^ {7{SEG_INV}};
        dp_d  = dp_act ^ SEG_INV;
        an_d  = an_act ^ {NUM_DIGITS{AN_INV}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            idx_q         <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            seg_q         <= {7{SEG_INV}};
            dp_q          <= SEG_INV;
            an_q          <= {NUM_DIGITS{AN_INV}};
        end else begin
            div_q         <= div_d;
            idx_q         <= idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg            = seg_q;
    assign dp             = dp_q;
    assign an             = an_q;
    assign update_pending = pending_q;
    assign frame_tick     = frame_tick_q;

endmodule

`default_nettype wire
